// File: rtl/qs_srt_pkg.sv
// rtl/qs_srt_pkg.sv - shared types, state encoding and jump encoder for the qs_srt sequencer
package qs_srt_pkg;

  localparam int QS_PC_W   = 8;
  localparam int QS_INST_W = 16;

  typedef logic [QS_PC_W-1:0]   pc_t;
  typedef logic [QS_INST_W-1:0] inst_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } ucode_state_t;

  // J opcode: {4'b0001, 4'b0000, target[7:0]}
  function automatic logic [15:0] j(input logic [7:0] target);
    return {4'b0001, 4'b0000, target};
  endfunction

  function automatic logic [15:0] j_err(input int err_pc);
    return j(err_pc[7:0]);
  endfunction

endpackage

// File: rtl/qs_srt_ucode_ram_array.sv
// rtl/qs_srt_ucode_ram_array.sv - DEPTH x INST_W store, one write port, registered read, no reset
module qs_srt_ucode_ram_array
  import qs_srt_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int INST_W = QS_INST_W,
  parameter int AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_rdata;

  // Read-before-write on a same-address collision; the top never relies on it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/qs_srt_ucode_ram.sv
// rtl/qs_srt_ucode_ram.sv - writable microcode control store with per-entry valid bits
module qs_srt_ucode_ram
  import qs_srt_pkg::*;
#(
  parameter int PC_W   = QS_PC_W,
  parameter int INST_W = QS_INST_W,
  parameter int DEPTH  = 256,
  parameter int ERR_PC = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ra_vld,
  input  logic [PC_W-1:0]   i_ra,
  output logic              o_rout_vld,
  output logic [INST_W-1:0] o_rout,
  output logic              o_fetch_err,
  input  logic              i_ld_vld,
  output logic              o_ld_rdy,
  input  logic [PC_W-1:0]   i_ld_addr,
  input  logic [INST_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_err,
  input  logic              i_reload,
  output logic              o_prog_rdy,
  output logic [PC_W:0]     o_prog_cnt
);

  localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0]     DEPTH_W = (PC_W+1)'(DEPTH);
  localparam logic [INST_W-1:0] J_ERR   = INST_W'(j_err(ERR_PC));

  ucode_state_t        r_state, w_state_nxt;
  logic [(1<<AW)-1:0]  r_valid;
  logic                r_ld_err;
  logic [PC_W:0]       r_prog_cnt;
  logic                r_rout_vld;
  logic                r_fetch_err;
  logic                r_use_err;

  logic                w_ld_acc;
  logic                w_ld_in_range;
  logic                w_we;
  logic                w_fetch;
  logic                w_ra_in_range;
  logic                w_fetch_bad;
  logic [INST_W-1:0]   w_rdata;

  assign o_ld_rdy      = (r_state != READY) && !i_reload;
  assign w_ld_acc      = i_ld_vld && o_ld_rdy && !i_rst;
  assign w_ld_in_range = {1'b0, i_ld_addr} < DEPTH_W;
  assign w_we          = w_ld_acc && w_ld_in_range;

  assign w_fetch       = i_ra_vld && !i_rst && !i_reload;
  assign w_ra_in_range = {1'b0, i_ra} < DEPTH_W;
  // r_valid is padded to a power of two so the index never leaves the vector
  assign w_fetch_bad   = (r_state != READY) || !w_ra_in_range || !r_valid[i_ra[AW-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    if (i_reload)      w_state_nxt = EMPTY;
    else if (w_ld_acc) w_state_nxt = i_ld_last ? READY : LOAD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid     <= '0;
      r_ld_err    <= 1'b0;
      r_prog_cnt  <= '0;
      r_rout_vld  <= 1'b0;
      r_fetch_err <= 1'b0;
      r_use_err   <= 1'b1;
    end else begin
      r_rout_vld  <= w_fetch;
      r_fetch_err <= w_fetch && w_fetch_bad;
      if (w_fetch) r_use_err <= w_fetch_bad;

      if (i_reload) begin
        r_valid    <= '0;
        r_ld_err   <= 1'b0;
        r_prog_cnt <= '0;
      end else if (w_ld_acc) begin
        if (w_ld_in_range) begin
          r_valid[i_ld_addr[AW-1:0]] <= 1'b1;
          if (r_prog_cnt < DEPTH_W) r_prog_cnt <= r_prog_cnt + 1'b1;
        end else begin
          r_ld_err <= 1'b1;
        end
      end
    end
  end

  qs_srt_ucode_ram_array #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .AW     (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (i_ld_addr[AW-1:0]),
    .i_wdata (i_ld_data),
    .i_re    (w_fetch && w_ra_in_range),
    .i_raddr (i_ra[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Holding r_use_err and the array read register keeps rout stable between fetches.
  assign o_rout      = r_use_err ? J_ERR : w_rdata;
  assign o_rout_vld  = r_rout_vld;
  assign o_fetch_err = r_fetch_err;
  assign o_ld_err    = r_ld_err;
  assign o_prog_rdy  = (r_state == READY);
  assign o_prog_cnt  = r_prog_cnt;

endmodule

// File: tb/tb_qs_srt_ucode_ram.sv
// tb/tb_qs_srt_ucode_ram.sv - scoreboard bench for qs_srt_ucode_ram at DEPTH=256 and DEPTH=64
module tb_qs_srt_ucode_ram;

  localparam logic [15:0] J_ERR = 16'h1080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ra_vld = 1'b0;
  logic [7:0]  ra = '0;
  logic        ld_vld = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        reload = 1'b0;

  logic        rv_a, fe_a, ldrdy_a, lderr_a, prdy_a;
  logic [15:0] rout_a;
  logic [8:0]  pcnt_a;
  logic        rv_b, fe_b, ldrdy_b, lderr_b, prdy_b;
  logic [15:0] rout_b;
  logic [8:0]  pcnt_b;

  always #5 clk = ~clk;

  qs_srt_ucode_ram #(.PC_W(8), .INST_W(16), .DEPTH(256), .ERR_PC(128)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_ra_vld(ra_vld), .i_ra(ra),
    .o_rout_vld(rv_a), .o_rout(rout_a), .o_fetch_err(fe_a),
    .i_ld_vld(ld_vld), .o_ld_rdy(ldrdy_a), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_ld_last(ld_last), .o_ld_err(lderr_a), .i_reload(reload),
    .o_prog_rdy(prdy_a), .o_prog_cnt(pcnt_a)
  );

  qs_srt_ucode_ram #(.PC_W(8), .INST_W(16), .DEPTH(64), .ERR_PC(128)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_ra_vld(ra_vld), .i_ra(ra),
    .o_rout_vld(rv_b), .o_rout(rout_b), .o_fetch_err(fe_b),
    .i_ld_vld(ld_vld), .o_ld_rdy(ldrdy_b), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_ld_last(ld_last), .o_ld_err(lderr_b), .i_reload(reload),
    .o_prog_rdy(prdy_b), .o_prog_cnt(pcnt_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          depth [2] = '{256, 64};
  int          m_state [2];
  bit          m_valid [2][256];
  logic [15:0] m_mem [2][256];
  bit          m_ld_err [2];
  int          m_cnt [2];
  logic [15:0] m_rout [2];
  bit          m_rv [2];
  bit          m_fe [2];
  logic [16:0] sb_a [$];
  logic [16:0] sb_b [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int d = depth[k];
    bit bad;
    if (rst) begin
      m_state[k] = 0;
      for (int i = 0; i < 256; i++) m_valid[k][i] = 1'b0;
      m_ld_err[k] = 1'b0;
      m_cnt[k] = 0;
      m_rv[k] = 1'b0;
      m_fe[k] = 1'b0;
      m_rout[k] = J_ERR;
      return;
    end
    if (reload) begin
      m_rv[k] = 1'b0;
      m_fe[k] = 1'b0;
    end else if (ra_vld) begin
      bad = (m_state[k] != 2) || (int'(ra) >= d) || !m_valid[k][ra];
      m_rout[k] = bad ? J_ERR : m_mem[k][ra];
      m_fe[k] = bad;
      m_rv[k] = 1'b1;
      if (k == 0) sb_a.push_back({bad, m_rout[k]});
      else        sb_b.push_back({bad, m_rout[k]});
    end else begin
      m_rv[k] = 1'b0;
      m_fe[k] = 1'b0;
    end
    if (reload) begin
      m_state[k] = 0;
      for (int i = 0; i < 256; i++) m_valid[k][i] = 1'b0;
      m_ld_err[k] = 1'b0;
      m_cnt[k] = 0;
    end else if (ld_vld && m_state[k] != 2) begin
      if (int'(ld_addr) < d) begin
        m_mem[k][ld_addr] = ld_data;
        m_valid[k][ld_addr] = 1'b1;
        if (m_cnt[k] < d) m_cnt[k]++;
      end else begin
        m_ld_err[k] = 1'b1;
      end
      m_state[k] = ld_last ? 2 : 1;
    end
  endtask

  task automatic check_outputs(input int k);
    string       nm = (k == 0) ? "a" : "b";
    logic        rv    = (k == 0) ? rv_a    : rv_b;
    logic        fe    = (k == 0) ? fe_a    : fe_b;
    logic [15:0] rout  = (k == 0) ? rout_a  : rout_b;
    logic        ldrdy = (k == 0) ? ldrdy_a : ldrdy_b;
    logic        lderr = (k == 0) ? lderr_a : lderr_b;
    logic        prdy  = (k == 0) ? prdy_a  : prdy_b;
    logic [8:0]  pcnt  = (k == 0) ? pcnt_a  : pcnt_b;
    logic [16:0] exp_rsp;
    check_eq({nm, " rout_vld"}, 32'(rv), 32'(m_rv[k]));
    if (rv) begin
      if ((k == 0 ? sb_a.size() : sb_b.size()) == 0) begin
        check_eq({nm, " unexpected response"}, 32'(rv), 32'd0);
      end else begin
        exp_rsp = (k == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check_eq({nm, " rout"}, 32'(rout), 32'(exp_rsp[15:0]));
        check_eq({nm, " fetch_err"}, 32'(fe), 32'(exp_rsp[16]));
      end
    end else begin
      check_eq({nm, " rout held"}, 32'(rout), 32'(m_rout[k]));
      check_eq({nm, " fetch_err idle"}, 32'(fe), 32'd0);
    end
    check_eq({nm, " ld_rdy"}, 32'(ldrdy), 32'((m_state[k] != 2) && !reload));
    check_eq({nm, " ld_err"}, 32'(lderr), 32'(m_ld_err[k]));
    check_eq({nm, " prog_rdy"}, 32'(prdy), 32'(m_state[k] == 2));
    check_eq({nm, " prog_cnt"}, 32'(pcnt), 32'(m_cnt[k]));
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic clr();
    rst = 1'b0; ra_vld = 1'b0; ld_vld = 1'b0; ld_last = 1'b0; reload = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d, input logic last);
    ld_vld = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    cyc();
    clr();
  endtask

  task automatic fetch(input logic [7:0] a);
    ra_vld = 1'b1; ra = a;
    cyc();
    clr();
  endtask

  initial begin
    // reset state, then fetch while EMPTY
    rst = 1'b1;
    cyc();
    clr();
    cyc();
    fetch(8'd0);
    cyc();

    // small program, back-to-back fetches
    load(8'd0, 16'h1060, 1'b0);
    load(8'd96, 16'h6001, 1'b1);
    fetch(8'd0);
    fetch(8'd96);
    cyc();

    // unloaded and out-of-range fetches in READY
    fetch(8'd5);
    fetch(8'd100);

    // out-of-range load beat followed by a last beat
    reload = 1'b1;
    cyc();
    clr();
    load(8'd70, 16'h7070, 1'b0);
    load(8'd1, 16'h2222, 1'b1);
    fetch(8'd70);
    fetch(8'd1);

    // reload right after a valid fetch; beat and fetch in the reload cycle are dropped
    fetch(8'd1);
    reload = 1'b1; ra_vld = 1'b1; ra = 8'd1; ld_vld = 1'b1; ld_addr = 8'd9; ld_data = 16'h9999;
    cyc();
    clr();
    fetch(8'd1);

    // rst mid-LOAD clears valid bits
    load(8'd2, 16'h0202, 1'b0);
    load(8'd3, 16'h0303, 1'b0);
    load(8'd4, 16'h0404, 1'b0);
    rst = 1'b1;
    cyc();
    clr();
    load(8'd0, 16'hA000, 1'b1);
    fetch(8'd3);
    fetch(8'd0);

    // prog_cnt saturation (64 for b), rewrites still count
    reload = 1'b1;
    cyc();
    clr();
    for (int i = 0; i < 67; i++) begin
      load(8'(i % 64), 16'($urandom), (i == 66));
    end

    // random fetch traffic in READY
    for (int i = 0; i < 40; i++) begin
      ra_vld = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      cyc();
      clr();
    end
    cyc();

    check_eq("a scoreboard drained", 32'(sb_a.size()), 32'd0);
    check_eq("b scoreboard drained", 32'(sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qs_srt_ucode_ram.md
Name: qs_srt_ucode_ram

Overview:
Writable, parametrised control store for the qs_srt microsequencer. It supersedes the fixed combinational microcode table.
- Program is downloaded at run time over a valid/ready load port.
- Fetch has 1-cycle registered latency.
- Per-entry valid bits; fetching any unprogrammed entry yields the error-trap jump instead of garbage.
- Sits between the sequencer PC register and the instruction decode stage.

Parameters:
PC_W, 8, fetch/load address width (pc_t width)
INST_W, 16, instruction width (inst_t width)
DEPTH, 256, number of entries; must be <= 2**PC_W
ERR_PC, 128, error-trap address embedded in the substituted jump

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ra_vld  in  1  fetch request
ra  in  PC_W  fetch address
rout_vld  out  1  fetch response valid, one cycle after ra_vld
rout  out  INST_W  fetched instruction
fetch_err  out  1  1-cycle pulse with rout_vld when the error jump was substituted
ld_vld  in  1  load beat valid
ld_rdy  out  1  load port ready
ld_addr  in  PC_W  load address
ld_data  in  INST_W  load instruction
ld_last  in  1  final beat of program
ld_err  out  1  sticky: out-of-range load seen; cleared by rst/reload
reload  in  1  discard program and return to EMPTY
prog_rdy  out  1  state == READY
prog_cnt  out  PC_W+1  count of accepted in-range beats, saturating at DEPTH

Behaviour:
Reset values:
- State is EMPTY; all valid bits are cleared.
- rout_vld=0, fetch_err=0, ld_err=0, prog_cnt=0.
- rout=J_ERR, i.e. {4'b0001, 4'b0000, ERR_PC[7:0]} zero-extended to INST_W.
- Array contents are not reset.

FSM:
- EMPTY -> LOAD on first accepted beat. If that beat has ld_last=1, go EMPTY -> READY directly.
- LOAD -> READY on an accepted beat with ld_last=1.
- Any state -> EMPTY on reload. The reload cycle also clears valid bits, ld_err and prog_cnt. A beat presented in the reload cycle is dropped.

Load port:
- ld_rdy = (state != READY) && !reload. A beat is accepted when ld_vld && ld_rdy.
- ld_addr < DEPTH: write array, set valid[ld_addr], increment prog_cnt. Rewriting an address increments prog_cnt again; the count is beats, not unique entries.
- ld_addr >= DEPTH: drop the data and set ld_err. ld_last is still honoured.

Fetch:
- Registered, latency 1: cycle N sample ra; cycle N+1 rout_vld=1, rout=data.
- Back-to-back fetches give one response per cycle; there is no backpressure.
- Substitute J_ERR and pulse fetch_err if any of:
  - state != READY
  - ra >= DEPTH
  - !valid[ra]
- When ra_vld=0: rout_vld=0 next cycle and rout holds its last value.
- Write and fetch of the same address in one cycle cannot occur with valid data, because fetch is only legal in READY and load only outside READY. A fetch in the write cycle sees the pre-write valid bit.
- rst or reload in cycle N suppresses the response in N+1: rout_vld=0.

Widths:
- ERR_PC is truncated to 8 bits in the J encoding.
- prog_cnt saturates at DEPTH.

Decomposition:
- Package qs_srt_pkg: add a ucode_state_t enum {EMPTY, LOAD, READY} and a J_ERR constructor function (reusing the existing j() encoder), plus the existing pc_t/inst_t.
- One sub-module, qs_srt_ucode_ram_array: DEPTH x INST_W, single write port, registered read port, no reset. Suits FPGA block-RAM inference.
- The valid-bit vector, FSM and error substitution live in the top.

Test Plan:
1. Reset, then fetch ra=0 -> next cycle rout_vld=1, rout=16'h1080, fetch_err=1; prog_rdy=0.
2. Load addr0=16'h1060, addr96=16'h6001 (last), then fetch 0, 96 back-to-back -> rout 16'h1060, then 16'h6001 on consecutive cycles; fetch_err=0; prog_cnt=2; ld_rdy=0.
3. In READY, fetch unloaded ra=5 -> rout=16'h1080, fetch_err=1; with DEPTH=64, fetch ra=100 -> the same result.
4. With DEPTH=64, load beat at addr 70 then addr 1 with last -> ld_err=1, prog_cnt=1, READY; fetch 70 -> J_ERR.
5. Assert reload in the cycle after a fetch of a valid entry -> response already issued is unaffected; the next fetch returns J_ERR; ld_rdy=1; prog_cnt=0; ld_err=0.
6. Assert rst mid-LOAD after 3 beats, then fetch a previously written address after reloading only addr 0 with last -> that address returns J_ERR, because valid bits were cleared.
